// File: rtl/nvdla_csb_master_pkg.sv
// nvdla_csb_master_pkg: CSB request/response packet layout, fixed request fields and FSM states.
package nvdla_csb_master_pkg;
    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 32;
    localparam int REQ_PD_W  = 63;
    localparam int RESP_PD_W = 34;
    localparam int CNT_W     = 16;

    localparam int REQ_ADDR_LSB    = 0;
    localparam int REQ_WDAT_LSB    = 22;
    localparam int REQ_WRITE_BIT   = 54;
    localparam int REQ_NPOSTED_BIT = 55;
    localparam int REQ_SRCPRIV_BIT = 56;
    localparam int REQ_WRBE_LSB    = 57;
    localparam int REQ_WRBE_W      = 4;
    localparam int REQ_LEVEL_LSB   = 61;
    localparam int REQ_LEVEL_W     = 2;

    localparam int RESP_DATA_LSB = 0;
    localparam int RESP_ERR_BIT  = 32;
    localparam int RESP_TYPE_BIT = 33;

    localparam logic                   SRCPRIV = 1'b0;
    localparam logic [REQ_WRBE_W-1:0]  WRBE    = 4'hF;
    localparam logic [REQ_LEVEL_W-1:0] LEVEL   = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RESP,
        ST_DONE
    } state_e;
endpackage

// File: rtl/nvdla_csb_req_pack.sv
// nvdla_csb_req_pack: combinational packer from command fields to the 63-bit CSB request packet.
module nvdla_csb_req_pack
    import nvdla_csb_master_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdat_i,
    input  logic                write_i,
    input  logic                nposted_i,
    output logic [REQ_PD_W-1:0] pd_o
);
    always_comb begin
        pd_o = '0;
        pd_o[REQ_ADDR_LSB +: ADDR_W]          = addr_i;
        pd_o[REQ_WDAT_LSB +: DATA_W]          = wdat_i;
        pd_o[REQ_WRITE_BIT]                   = write_i;
        pd_o[REQ_NPOSTED_BIT]                 = nposted_i;
        pd_o[REQ_SRCPRIV_BIT]                 = SRCPRIV;
        pd_o[REQ_WRBE_LSB +: REQ_WRBE_W]      = WRBE;
        pd_o[REQ_LEVEL_LSB +: REQ_LEVEL_W]    = LEVEL;
    end
endmodule

// File: rtl/nvdla_csb_master.sv
// nvdla_csb_master: single-outstanding CSB master turning commands into req/resp transactions
// with timeout, error/type checking and a sticky stray-response flag.
module nvdla_csb_master
    import nvdla_csb_master_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdat,
    input  logic                  cmd_write,
    input  logic                  cmd_nposted,
    output logic                  csb2glb_req_pvld,
    input  logic                  csb2glb_req_prdy,
    output logic [REQ_PD_W-1:0]   csb2glb_req_pd,
    input  logic                  glb2csb_resp_valid,
    input  logic [RESP_PD_W-1:0]  glb2csb_resp_pd,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdat,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  stray_resp
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdat_q;
    logic                write_q, nposted_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic                err_q, err_d, tmo_q, tmo_d, stray_q, stray_d;
    logic [REQ_PD_W-1:0] pkt;
    logic                resp_err, resp_type;

    assign resp_err  = glb2csb_resp_pd[RESP_ERR_BIT];
    assign resp_type = glb2csb_resp_pd[RESP_TYPE_BIT];

    nvdla_csb_req_pack u_pack (
        .addr_i    (addr_q),
        .wdat_i    (wdat_q),
        .write_i   (write_q),
        .nposted_i (nposted_q),
        .pd_o      (pkt)
    );

    // Reset gates cmd_ready directly so it reads 0 for every cycle reset is held.
    assign cmd_ready        = (state_q == ST_IDLE) && !nvdla_core_rst;
    assign csb2glb_req_pvld = (state_q == ST_REQ);
    assign csb2glb_req_pd   = csb2glb_req_pvld ? pkt : '0;
    assign rsp_valid        = (state_q == ST_DONE);
    assign rsp_rdat         = rdat_q;
    assign rsp_err          = err_q;
    assign rsp_timeout      = tmo_q;
    assign stray_resp       = stray_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        stray_d = stray_q | (glb2csb_resp_valid && state_q != ST_WAIT_RESP);
        unique case (state_q)
            ST_IDLE: state_d = (cmd_valid && cmd_ready) ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                if (csb2glb_req_prdy) begin
                    if (write_q && !nposted_q) begin
                        state_d = ST_DONE;
                        rdat_d  = '0;
                        err_d   = 1'b0;
                        tmo_d   = 1'b0;
                    end else begin
                        state_d = ST_WAIT_RESP;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (glb2csb_resp_valid) begin
                    state_d = ST_DONE;
                    rdat_d  = write_q ? '0 : glb2csb_resp_pd[RESP_DATA_LSB +: DATA_W];
                    err_d   = resp_err | (resp_type != write_q);
                    tmo_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    rdat_d  = '0;
                    err_d   = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = rsp_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            stray_q   <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            write_q   <= 1'b0;
            nposted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            stray_q <= stray_d;
            if (cmd_valid && cmd_ready) begin
                addr_q    <= cmd_addr;
                wdat_q    <= cmd_wdat;
                write_q   <= cmd_write;
                nposted_q <= cmd_nposted | ~cmd_write;
            end
        end
    end
endmodule

// File: tb/tb_nvdla_csb_master.sv
// tb_nvdla_csb_master: scoreboard bench; expected results queued at issue, popped on rsp handshake.
module tb_nvdla_csb_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_nposted;
    logic [21:0] cmd_addr;
    logic [31:0] cmd_wdat;
    logic        req_pvld, req_prdy;
    logic [62:0] req_pd;
    logic        resp_valid;
    logic [33:0] resp_pd;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, stray_resp;
    logic [31:0] rsp_rdat;

    typedef struct {
        logic [31:0] rdat;
        logic        err;
        logic        tmo;
    } res_t;

    res_t        exp_q[$];
    int          n_chk = 0, n_pass = 0, n_push = 0, n_done = 0;
    logic [62:0] last_pd;

    always #5 clk = ~clk;

    nvdla_csb_master #(.TIMEOUT(8)) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rst     (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_wdat           (cmd_wdat),
        .cmd_write          (cmd_write),
        .cmd_nposted        (cmd_nposted),
        .csb2glb_req_pvld   (req_pvld),
        .csb2glb_req_prdy   (req_prdy),
        .csb2glb_req_pd     (req_pd),
        .glb2csb_resp_valid (resp_valid),
        .glb2csb_resp_pd    (resp_pd),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rdat           (rsp_rdat),
        .rsp_err            (rsp_err),
        .rsp_timeout        (rsp_timeout),
        .stray_resp         (stray_resp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [62:0] pkt(input logic [21:0] a, input logic [31:0] d,
                                        input logic w, input logic np);
        return {2'b00, 4'hF, 1'b0, np | ~w, w, d, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input logic [31:0] d, input logic e, input logic t);
        res_t r;
        r.rdat = d;
        r.err  = e;
        r.tmo  = t;
        exp_q.push_back(r);
        n_push++;
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                n_done++;
                chk("rsp_rdat", 64'(rsp_rdat), 64'(r.rdat));
                chk("rsp_err", 64'(rsp_err), 64'(r.err));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(r.tmo));
            end
        end
    end

    task automatic issue(input logic [21:0] a, input logic [31:0] d, input logic w, input logic np);
        int n = 0;
        cmd_addr = a; cmd_wdat = d; cmd_write = w; cmd_nposted = np; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        last_pd = pkt(a, d, w, np);
        chk("req_pvld_lat", 64'(req_pvld), 64'd1);
        chk("req_pd", 64'(req_pd), 64'(last_pd));
    endtask

    task automatic accept_req(input int stall);
        req_prdy = 1'b0;
        repeat (stall) begin
            tick();
            chk("pd_stable", 64'(req_pd), 64'(last_pd));
            chk("pvld_held", 64'(req_pvld), 64'd1);
        end
        req_prdy = 1'b1;
        tick();
        req_prdy = 1'b0;
        chk("pvld_drop", 64'(req_pvld), 64'd0);
    endtask

    task automatic respond(input logic t, input logic e, input logic [31:0] d);
        resp_valid = 1'b1;
        resp_pd = {t, e, d};
        tick();
        resp_valid = 1'b0;
        resp_pd = '0;
        chk("rsp_valid_lat", 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_addr = 0; cmd_wdat = 0; cmd_write = 0; cmd_nposted = 0;
        req_prdy = 0; resp_valid = 0; resp_pd = 0; rsp_ready = 1'b1;
        repeat (2) tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 0);
        chk("rst_pvld", 64'(req_pvld), 0);
        chk("rst_pd", 64'(req_pd), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rdat", 64'(rsp_rdat), 0);
        chk("rst_err", 64'(rsp_err), 0);
        chk("rst_timeout", 64'(rsp_timeout), 0);
        chk("rst_stray", 64'(stray_resp), 0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", 64'(cmd_ready), 1);

        // read with a 3-cycle request stall
        expect_res(32'hDEADBEEF, 0, 0);
        issue(22'h000004, 32'h0, 1'b0, 1'b0);
        accept_req(3);
        repeat (2) tick();
        respond(1'b0, 1'b0, 32'hDEADBEEF);
        tick();

        // posted write: done one cycle after prdy
        expect_res(32'h0, 0, 0);
        issue(22'h00000C, 32'h0000_00FF, 1'b1, 1'b0);
        chk("pw_wdat", 64'(req_pd[53:22]), 64'hFF);
        chk("pw_nposted", 64'(req_pd[55]), 0);
        req_prdy = 1'b1;
        tick();
        req_prdy = 1'b0;
        chk("pw_rsp_valid", 64'(rsp_valid), 1);
        tick();

        // non-posted write: error bit, then type mismatch
        expect_res(32'h0, 1, 0);
        issue(22'h000008, 32'h1234, 1'b1, 1'b1);
        accept_req(1);
        respond(1'b1, 1'b1, 32'h0);
        tick();
        expect_res(32'h0, 1, 0);
        issue(22'h000008, 32'h5678, 1'b1, 1'b1);
        accept_req(0);
        respond(1'b0, 1'b0, 32'hCAFE);
        tick();

        // timeout exactly 8 cycles into WAIT_RESP
        expect_res(32'h0, 0, 1);
        issue(22'h000010, 32'h0, 1'b0, 1'b0);
        accept_req(0);
        repeat (7) tick();
        chk("tmo_not_early", 64'(rsp_valid), 0);
        tick();
        chk("tmo_valid", 64'(rsp_valid), 1);
        chk("tmo_flag", 64'(rsp_timeout), 1);
        tick();

        // response on the final cycle beats the timeout
        expect_res(32'h55AA, 0, 0);
        issue(22'h000014, 32'h0, 1'b0, 1'b0);
        accept_req(0);
        repeat (7) tick();
        respond(1'b0, 1'b0, 32'h55AA);
        chk("late_resp_no_tmo", 64'(rsp_timeout), 0);
        tick();

        // stray response while idle is sticky
        chk("stray_clear", 64'(stray_resp), 0);
        resp_valid = 1'b1; resp_pd = {2'b00, 32'h9999};
        tick();
        resp_valid = 1'b0; resp_pd = '0;
        chk("stray_set", 64'(stray_resp), 1);
        chk("stray_no_rsp", 64'(rsp_valid), 0);
        repeat (3) tick();
        chk("stray_sticky", 64'(stray_resp), 1);
        expect_res(32'h1111_2222, 0, 0);
        issue(22'h000018, 32'h0, 1'b0, 1'b0);
        accept_req(0);
        respond(1'b0, 1'b0, 32'h1111_2222);
        tick();
        chk("stray_still", 64'(stray_resp), 1);

        // results held while rsp_ready is low
        rsp_ready = 1'b0;
        expect_res(32'hABCD, 0, 0);
        issue(22'h00001C, 32'h0, 1'b0, 1'b0);
        accept_req(0);
        respond(1'b0, 1'b0, 32'hABCD);
        repeat (5) begin
            tick();
            chk("hold_valid", 64'(rsp_valid), 1);
            chk("hold_rdat", 64'(rsp_rdat), 64'hABCD);
            chk("hold_cmd_ready", 64'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("release_valid", 64'(rsp_valid), 0);
        chk("release_cmd_ready", 64'(cmd_ready), 1);

        // reset during WAIT_RESP abandons the access
        issue(22'h000020, 32'h0, 1'b0, 1'b0);
        accept_req(0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(rsp_valid), 0);
        chk("mid_rst_stray", 64'(stray_resp), 0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 1);
        repeat (3) begin
            tick();
            chk("post_rst_no_valid", 64'(rsp_valid), 0);
        end
        resp_valid = 1'b1; resp_pd = {2'b00, 32'h7777};
        tick();
        resp_valid = 1'b0; resp_pd = '0;
        chk("post_rst_stray", 64'(stray_resp), 1);
        chk("post_rst_idle", 64'(rsp_valid), 0);

        repeat (2) tick();
        chk("sb_empty", 64'(exp_q.size()), 0);
        chk("sb_done", 64'(n_done), 64'(n_push));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nvdla_csb_master.md
NVDLA_CSB_MASTER -- requirements
Module: nvdla_csb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: cycles in WAIT_RESP before a non-posted access is aborted (legal range 2..65535).
REQ-002 SHALL have these ports, in this order:
- nvdla_core_clk  in  1  sole clock.
- nvdla_core_rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_addr  in  22  register word address.
- cmd_wdat  in  32  write data.
- cmd_write  in  1  1=write, 0=read.
- cmd_nposted  in  1  write expects ack (ignored for reads; reads are always non-posted).
- csb2glb_req_pvld  out  1  request valid.
- csb2glb_req_prdy  in  1  request accepted.
- csb2glb_req_pd  out  63  request packet.
- glb2csb_resp_valid  in  1  response pulse; no back-pressure.
- glb2csb_resp_pd  in  34  response packet.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_rdat  out  32  read data (0 for writes).
- rsp_err  out  1  responder error bit, or type mismatch.
- rsp_timeout  out  1  access aborted by timeout.
- stray_resp  out  1  sticky: response arrived outside WAIT_RESP.

Function
REQ-003 Request packet SHALL be: [21:0] addr, [53:22] wdat, [54] write, [55] nposted (1 for reads), [56] srcpriv=0, [60:57] wrbe=4'hF, [62:61] level=0.
REQ-004 Response packet SHALL be: [31:0] data, [32] error, [33] type (0=read data, 1=write ack).
REQ-005 FSM states SHALL be IDLE, REQ, WAIT_RESP and DONE.
REQ-006 cmd_ready SHALL be 1 only in IDLE; an accepted command SHALL be registered and the FSM SHALL move to REQ on the next cycle.
REQ-007 In REQ, csb2glb_req_pvld SHALL be 1 and the packet SHALL be held stable until csb2glb_req_prdy=1.
REQ-008 On REQ acceptance of a posted write (write=1, nposted=0), the FSM SHALL go to DONE with rsp_rdat=0, rsp_err=0, rsp_timeout=0.
REQ-009 On REQ acceptance of any other command, the FSM SHALL go to WAIT_RESP and clear the timeout counter.
REQ-010 A response in the same cycle as acceptance SHALL NOT be consumed as this command's response; it SHALL set stray_resp.
REQ-011 In WAIT_RESP, glb2csb_resp_valid=1 SHALL latch the result, with rsp_rdat = data for reads and 0 for writes, and go to DONE.
- rsp_err = error | (type != write).
REQ-012 The WAIT_RESP counter SHALL increment each cycle; on reaching TIMEOUT-1 with no response, the FSM SHALL go to DONE with rsp_timeout=1, rsp_err=0, rsp_rdat=0.
REQ-013 If a response and the timeout occur in the same cycle, the response SHALL win.
REQ-014 In DONE, rsp_valid SHALL be 1 and results SHALL be held stable until rsp_ready=1, then the FSM SHALL go to IDLE; a new command SHALL NOT be accepted in that same cycle.
REQ-015 glb2csb_resp_valid in IDLE, REQ or DONE SHALL set stray_resp, which SHALL stay set until reset; the result registers SHALL be unaffected.
REQ-016 Latency SHALL be: cmd accept to req_pvld = 1 cycle; resp_valid to rsp_valid = 1 cycle; posted write prdy to rsp_valid = 1 cycle.
REQ-017 Counter width SHALL be 16 bits with no wrap; it saturates at TIMEOUT-1.

Reset
REQ-018 While nvdla_core_rst=1 at a clock edge, the FSM SHALL go to IDLE and all of these outputs SHALL be 0: cmd_ready, csb2glb_req_pvld, csb2glb_req_pd, rsp_valid, rsp_rdat, rsp_err, rsp_timeout, stray_resp.
- The counter SHALL be 0.
REQ-019 Reset mid-access SHALL abandon the access with no rsp_valid; a response arriving after reset deasserts SHALL set stray_resp.
REQ-020 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-021 The shared package SHALL hold the request/response field offsets and widths, the srcpriv/wrbe/level constants and the FSM state enum.
REQ-022 The request packer SHALL be one sub-module, nvdla_csb_req_pack (command fields in, 63-bit packet out, combinational); all else SHALL be in the top module.

Verification
REQ-023 Read: cmd addr=22'h000004, write=0; prdy held low 3 cycles, then resp pd={1'b0,1'b0,32'hDEADBEEF} -> rsp_rdat=32'hDEADBEEF, rsp_err=0, pd stable during stall.
REQ-024 Posted write: addr=22'h00000C, wdat=32'h0000_00FF, nposted=0, prdy=1 -> pd[53:22]=32'hFF, pd[55]=0, rsp_valid 1 cycle after prdy, no wait.
REQ-025 Non-posted write with resp pd={1'b1,1'b1,32'h0} -> rsp_err=1; repeat with type=0 -> rsp_err=1 (mismatch).
REQ-026 TIMEOUT=8, read with no response -> rsp_timeout=1 exactly 8 cycles after entering WAIT_RESP; response on the 8th cycle -> normal result, no timeout.
REQ-027 Response pulse while IDLE -> stray_resp=1 and sticky, next read completes correctly; reset asserted during WAIT_RESP -> IDLE, no rsp_valid.
REQ-028 Hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable and cmd_ready=0 throughout.
